// File: rtl/accel_gen.sv
// Accelerometer stimulus generator: builds a 14-bit sample per frame and sends it
// as two 8N1 UART bytes on TX_A, separated from the next frame by an idle gap.
module accel_gen #(
    parameter int          BAUD_DIV  = 16,
    parameter int          FRAME_GAP = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    output logic        TX_A,
    output logic [13:0] tx_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    typedef enum logic [2:0] {
        S_GAP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic          byte_sel;
    logic [GW-1:0] gap_cnt;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [2:0]    corner_idx;
    logic [13:0]   corner_val;
    logic [13:0]   ramp;
    logic [7:0]    cur_byte;
    logic          baud_last;
    logic          gap_last;

    assign baud_last = (baud_cnt == BW'(BAUD_DIV - 1));
    assign gap_last  = (gap_cnt == GW'(FRAME_GAP - 1));
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign cur_byte  = byte_sel ? tx_data[7:0] : {2'b00, tx_data[13:8]};

    always_comb begin
        case (corner_idx)
            3'd0:    corner_val = 14'h1FFF;
            3'd1:    corner_val = 14'h2000;
            3'd2:    corner_val = 14'h3FFF;
            3'd3:    corner_val = 14'h0001;
            default: corner_val = 14'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_GAP;
        end else begin
            state <= state_next;
        end
    end

    // TX_A, busy and frame_done are decoded straight from the registered state,
    // so an asynchronous reset forces the line idle without waiting for a clock.
    always_comb begin
        state_next = state;
        TX_A       = 1'b1;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_GAP: begin
                if (gap_last) state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_START;
            end
            S_START: begin
                TX_A = 1'b0;
                busy = 1'b1;
                if (baud_last) state_next = S_DATA;
            end
            S_DATA: begin
                TX_A = cur_byte[bit_idx];
                busy = 1'b1;
                if (baud_last && bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: begin
                busy = 1'b1;
                if (baud_last) state_next = byte_sel ? S_DONE : S_START;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_next = S_GAP;
            end
            default: begin
                state_next = S_GAP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_sel   <= 1'b0;
            gap_cnt    <= '0;
            lfsr       <= LFSR_SEED;
            corner_idx <= '0;
            ramp       <= '0;
            tx_data    <= '0;
        end else begin
            if (state == S_GAP) begin
                gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
            end

            if (state == S_START || state == S_DATA || state == S_STOP) begin
                baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
            end

            if (state == S_DATA && baud_last) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (state == S_STOP && baud_last) begin
                byte_sel <= 1'b1;
            end

            // Each generator only advances on frames that actually use it.
            if (state == S_LOAD) begin
                byte_sel <= 1'b0;
                bit_idx  <= '0;
                case (mode)
                    2'd0: tx_data <= 14'h0000;
                    2'd1: begin
                        lfsr    <= lfsr_next;
                        tx_data <= lfsr_next[13:0];
                    end
                    2'd2: begin
                        tx_data    <= corner_val;
                        corner_idx <= (corner_idx == 3'd4) ? 3'd0 : corner_idx + 3'd1;
                    end
                    default: begin
                        tx_data <= ramp;
                        ramp    <= ramp + 14'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accel_gen.sv
// Directed bench for accel_gen: decodes TX_A with fixed mid-bit sampling and
// checks timing, bytes and sample sequences against hand-computed values.
module tb_accel_gen;

    localparam int BAUD_DIV  = 16;
    localparam int FRAME_GAP = 64;
    localparam int FRAME_CYC = 20 * BAUD_DIV;
    localparam int PERIOD    = 1 + FRAME_CYC + 1 + FRAME_GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        tx_a;
    logic [13:0] tx_data;
    logic        busy;
    logic        frame_done;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int rel_cyc = 0;

    accel_gen #(
        .BAUD_DIV(BAUD_DIV),
        .FRAME_GAP(FRAME_GAP),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .TX_A(tx_a),
        .tx_data(tx_data),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Returns at the negedge one frame length after the start bit was seen, which
    // is the frame_done cycle. busy_len counts busy from the negedge before the
    // start bit through that final negedge.
    task automatic recv_frame(output logic [7:0] b0, output logic [7:0] b1,
                              output int t_start, output int busy_len,
                              output logic done_end, output bit ok);
        logic [19:0] bits;
        logic        prev_busy;
        int          waited;
        ok = 1'b1;
        bits = '0;
        b0 = '0;
        b1 = '0;
        t_start = 0;
        busy_len = 0;
        done_end = 1'b0;
        waited = 0;
        prev_busy = busy;
        @(negedge clk);
        while (tx_a !== 1'b0 && waited < 4 * PERIOD) begin
            prev_busy = busy;
            @(negedge clk);
            waited++;
        end
        if (tx_a !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        t_start = cyc;
        if (prev_busy === 1'b1) busy_len++;
        if (busy === 1'b1) busy_len++;
        for (int off = 1; off <= FRAME_CYC; off++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_len++;
            if (off % BAUD_DIV == BAUD_DIV / 2) bits[(off - BAUD_DIV / 2) / BAUD_DIV] = tx_a;
        end
        done_end = frame_done;
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[10] !== 1'b0 || bits[19] !== 1'b1 ||
            tx_a !== 1'b1)
            ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b0[i] = bits[1 + i];
            b1[i] = bits[11 + i];
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        rst = 1'b1;
        mode = m;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if (tx_a !== 1'b1) begin fails++; $display("[TB] FAIL reset_tx_a: got %b expected 1", tx_a); end
        tests++;
        if (tx_data !== 14'h0000) begin fails++; $display("[TB] FAIL reset_tx_data: got %h expected 0000", tx_data); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests++;
        if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        mode = 2'd0;
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_zeros;
        logic [7:0] b0, b1;
        int t1, t2, bl;
        logic de;
        bit ok;
        recv_frame(b0, b1, t1, bl, de, ok);
        tests++;
        if (!ok) begin fails++; $display("[TB] FAIL zeros_frame_ok: got %b expected 1", ok); end
        tests++;
        if (t1 - rel_cyc != FRAME_GAP + 1) begin fails++; $display("[TB] FAIL zeros_first_start: got %0d expected %0d", t1 - rel_cyc, FRAME_GAP + 1); end
        tests++;
        if (b0 !== 8'h00 || b1 !== 8'h00) begin fails++; $display("[TB] FAIL zeros_bytes: got %h %h expected 00 00", b0, b1); end
        tests++;
        if (tx_data !== 14'h0000) begin fails++; $display("[TB] FAIL zeros_tx_data: got %h expected 0000", tx_data); end
        tests++;
        if (bl != FRAME_CYC) begin fails++; $display("[TB] FAIL zeros_busy_len: got %0d expected %0d", bl, FRAME_CYC); end
        tests++;
        if (de !== 1'b1) begin fails++; $display("[TB] FAIL zeros_done_pulse: got %b expected 1", de); end
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL zeros_done_width: got %b expected 0", frame_done); end
        recv_frame(b0, b1, t2, bl, de, ok);
        tests++;
        if (!ok || t2 - t1 != PERIOD) begin fails++; $display("[TB] FAIL zeros_period: got %0d ok=%b expected %0d", t2 - t1, ok, PERIOD); end
    endtask

    task automatic test_corner;
        logic [13:0] exp_v [6] = '{14'h1FFF, 14'h2000, 14'h3FFF, 14'h0001, 14'h0000, 14'h1FFF};
        logic [7:0]  exp_b0 [6] = '{8'h1F, 8'h20, 8'h3F, 8'h00, 8'h00, 8'h1F};
        logic [7:0]  exp_b1 [6] = '{8'hFF, 8'h00, 8'hFF, 8'h01, 8'h00, 8'hFF};
        logic [7:0] b0, b1;
        int t, bl;
        logic de;
        bit ok;
        do_reset(2'd2);
        for (int i = 0; i < 6; i++) begin
            recv_frame(b0, b1, t, bl, de, ok);
            tests++;
            if (!ok || tx_data !== exp_v[i]) begin fails++; $display("[TB] FAIL corner_value[%0d]: got %h ok=%b expected %h", i, tx_data, ok, exp_v[i]); end
            tests++;
            if (b0 !== exp_b0[i] || b1 !== exp_b1[i]) begin fails++; $display("[TB] FAIL corner_bytes[%0d]: got %h %h expected %h %h", i, b0, b1, exp_b0[i], exp_b1[i]); end
        end
    endtask

    task automatic test_random;
        logic [13:0] exp_v [3] = '{14'h19C3, 14'h3387, 14'h270F};
        logic [7:0]  exp_b0 [3] = '{8'h19, 8'h33, 8'h27};
        logic [7:0]  exp_b1 [3] = '{8'hC3, 8'h87, 8'h0F};
        logic [7:0] b0, b1;
        int t, bl;
        logic de;
        bit ok;
        do_reset(2'd1);
        for (int i = 0; i < 3; i++) begin
            recv_frame(b0, b1, t, bl, de, ok);
            tests++;
            if (!ok || tx_data !== exp_v[i]) begin fails++; $display("[TB] FAIL random_value[%0d]: got %h ok=%b expected %h", i, tx_data, ok, exp_v[i]); end
            tests++;
            if (b0 !== exp_b0[i] || b1 !== exp_b1[i]) begin fails++; $display("[TB] FAIL random_bytes[%0d]: got %h %h expected %h %h", i, b0, b1, exp_b0[i], exp_b1[i]); end
        end
    endtask

    task automatic test_ramp_then_corner;
        logic [7:0] b0, b1;
        int t, bl;
        logic de;
        bit ok;
        do_reset(2'd3);
        for (int i = 0; i < 3; i++) begin
            recv_frame(b0, b1, t, bl, de, ok);
            tests++;
            if (!ok || tx_data !== 14'(i) || b0 !== 8'h00 || b1 !== 8'(i)) begin
                fails++;
                $display("[TB] FAIL ramp_value[%0d]: got %h bytes %h %h ok=%b expected %h", i, tx_data, b0, b1, ok, i);
            end
        end
        mode = 2'd2;
        recv_frame(b0, b1, t, bl, de, ok);
        tests++;
        if (!ok || tx_data !== 14'h1FFF || b0 !== 8'h1F || b1 !== 8'hFF) begin
            fails++;
            $display("[TB] FAIL ramp_to_corner: got %h bytes %h %h ok=%b expected 1fff", tx_data, b0, b1, ok);
        end
    endtask

    // Ramp and corner generators are left at 3 and 1 by the previous test; LFSR is still at its seed.
    task automatic test_mode_toggle;
        logic [7:0] b0, b1;
        int t, bl, w;
        logic de;
        bit ok;
        bit saw_busy;
        mode = 2'd3;
        saw_busy = 1'b0;
        fork
            recv_frame(b0, b1, t, bl, de, ok);
            begin
                w = 0;
                while (busy !== 1'b1 && w < 4 * PERIOD) begin
                    @(negedge clk);
                    w++;
                end
                saw_busy = (busy === 1'b1);
                repeat (40) @(negedge clk);
                mode = 2'd1;
                repeat (100) @(negedge clk);
                mode = 2'd0;
                repeat (50) @(negedge clk);
                mode = 2'd1;
            end
        join
        tests++;
        if (!saw_busy) begin fails++; $display("[TB] FAIL toggle_busy_seen: got %b expected 1", saw_busy); end
        tests++;
        if (!ok || tx_data !== 14'h0003 || b0 !== 8'h00 || b1 !== 8'h03) begin
            fails++;
            $display("[TB] FAIL toggle_inflight: got %h bytes %h %h ok=%b expected 0003 bytes 00 03", tx_data, b0, b1, ok);
        end
        recv_frame(b0, b1, t, bl, de, ok);
        tests++;
        if (!ok || tx_data !== 14'h19C3 || b0 !== 8'h19 || b1 !== 8'hC3) begin
            fails++;
            $display("[TB] FAIL toggle_next_mode: got %h bytes %h %h ok=%b expected 19c3", tx_data, b0, b1, ok);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b0, b1;
        int t, bl, w;
        logic de;
        bit ok;
        mode = 2'd2;
        w = 0;
        @(negedge clk);
        while (busy !== 1'b1 && w < 4 * PERIOD) begin
            @(negedge clk);
            w++;
        end
        repeat (BAUD_DIV + 20) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("[TB] FAIL midreset_in_frame: got busy %b expected 1", busy); end
        rst = 1'b1;
        #1;
        tests++;
        if (tx_a !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL midreset_idle: got tx_a %b busy %b expected 1 0", tx_a, busy); end
        tests++;
        if (tx_data !== 14'h0000) begin fails++; $display("[TB] FAIL midreset_tx_data: got %h expected 0000", tx_data); end
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        recv_frame(b0, b1, t, bl, de, ok);
        tests++;
        if (!ok || t - rel_cyc != FRAME_GAP + 1) begin fails++; $display("[TB] FAIL midreset_gap: got %0d ok=%b expected %0d", t - rel_cyc, ok, FRAME_GAP + 1); end
        tests++;
        if (tx_data !== 14'h1FFF || b0 !== 8'h1F || b1 !== 8'hFF) begin
            fails++;
            $display("[TB] FAIL midreset_corner: got %h bytes %h %h expected 1fff bytes 1f ff", tx_data, b0, b1);
        end
    endtask

    initial begin
        test_reset;
        test_zeros;
        test_corner;
        test_random;
        test_ramp_then_corner;
        test_mode_toggle;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
